// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller (16 lines x 256 b) with a hit/miss FSM.
// Optional hit/miss performance counters are built only when DCACHE_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic [3:0]   sram_index_o,
    output logic [24:0]  sram_tag_o,
    output logic [255:0] sram_data_o,
    output logic         sram_enable_o,
    output logic         sram_write_o,
    input  logic [24:0]  sram_tag_i,
    input  logic [255:0] sram_data_i,
    input  logic         sram_hit_i,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
);

    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, READMISSOK} state_t;

    state_t       state_reg, state_next;
    logic [22:0]  cpu_tag;
    logic [3:0]   cpu_index;
    logic [2:0]   cpu_offset;
    logic         req, is_write;
    logic [255:0] merged_line;
    logic [31:0]  sel_word;
    logic         hit_evt, miss_evt;
    logic         unused_addr_lsb;

    assign cpu_tag         = cpu_addr_i[31:9];
    assign cpu_index       = cpu_addr_i[8:5];
    assign cpu_offset      = cpu_addr_i[4:2];
    assign unused_addr_lsb = &{1'b0, cpu_addr_i[1:0]};
    assign req             = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_write        = cpu_MemWrite_i;
    assign sel_word        = sram_data_i[{cpu_offset, 5'b0} +: 32];

    // Line image for a write hit: only the addressed word takes the CPU data.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_word
            assign merged_line[gi*32 +: 32] = (cpu_offset == 3'(gi)) ? cpu_data_i
                                                                      : sram_data_i[gi*32 +: 32];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Every output is held at zero while reset is asserted, independent of the clock.
    always_comb begin
        state_next    = state_reg;
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b0;
        sram_index_o  = '0;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        hit_evt       = 1'b0;
        miss_evt      = 1'b0;
        if (rst_n_i) begin
            sram_index_o  = cpu_index;
            sram_enable_o = 1'b1;
            case (state_reg)
                IDLE: begin
                    sram_enable_o = req;
                    cpu_data_o    = sel_word;
                    if (req && sram_hit_i) begin
                        hit_evt = 1'b1;
                        if (is_write) begin
                            sram_write_o = 1'b1;
                            sram_data_o  = merged_line;
                            sram_tag_o   = {2'b11, cpu_tag};
                        end
                    end else if (req) begin
                        cpu_stall_o = 1'b1;
                        miss_evt    = 1'b1;
                        state_next  = MISS;
                    end
                end
                MISS: begin
                    cpu_stall_o = 1'b1;
                    state_next  = (sram_tag_i[24] && sram_tag_i[23]) ? WRITEBACK : READMISS;
                end
                WRITEBACK: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {sram_tag_i[22:0], cpu_index, 5'b0};
                    mem_data_o   = sram_data_i;
                    if (mem_ack_i) state_next = READMISS;
                end
                READMISS: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {cpu_tag, cpu_index, 5'b0};
                    if (mem_ack_i) begin
                        sram_write_o = 1'b1;
                        sram_tag_o   = {2'b10, cpu_tag};
                        sram_data_o  = mem_data_i;
                        state_next   = READMISSOK;
                    end
                end
                READMISSOK: begin
                    cpu_stall_o = 1'b1;
                    state_next  = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_reg, miss_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if (hit_evt)  hit_cnt_reg  <= hit_cnt_reg + 32'd1;
            if (miss_evt) miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_reg;
    assign miss_cnt_o = miss_cnt_reg;
`else
    logic unused_evt;
    assign unused_evt = hit_evt | miss_evt;
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule
